// File: rtl/regw_arbiter.sv
// Register-file write-port arbiter: merges write-back stage writes with a
// 2-entry FIFO of long-latency unit writes, forcing a pipeline stall on starvation.
module regw_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_pipe_RegWrite,
    input  logic [4:0]  i_pipe_RegAddrW,
    input  logic [31:0] i_pipe_RegDataW,
    input  logic        i_lu_valid,
    output logic        o_lu_ready,
    input  logic [4:0]  i_lu_addr,
    input  logic [31:0] i_lu_data,
    output logic        o_reg_RegWrite,
    output logic [4:0]  o_reg_RegAddrW,
    output logic [31:0] o_reg_RegDataW,
    output logic        o_stall,
    output logic [31:0] o_pend_mask
);

    typedef enum logic [0:0] {ST_NORMAL = 1'b0, ST_STALL = 1'b1} state_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    state_t      state_r, state_nxt_s;
    logic [3:0]  starve_r, starve_nxt_s;
    logic [4:0]  fifo_addr_r [2];
    logic [31:0] fifo_data_r [2];
    logic [1:0]  fifo_vld_r;
    logic        wr_ptr_r, rd_ptr_r;

    logic        pipe_req_s, fifo_full_s, fifo_empty_s, push_s;
    logic        grant_pipe_s, grant_fifo_s;
    logic [31:0] pend_mask_s;

    // Entries are contiguous, so slot occupancy at each pointer gives full/empty.
    assign fifo_full_s  = fifo_vld_r[wr_ptr_r];
    assign fifo_empty_s = ~fifo_vld_r[rd_ptr_r];
    assign o_lu_ready   = ~fifo_full_s;
    assign pipe_req_s   = i_pipe_RegWrite & (i_pipe_RegAddrW != 5'd0);
    assign push_s       = i_lu_valid & ~fifo_full_s & (i_lu_addr != 5'd0);
    assign o_stall      = (state_r == ST_STALL);
    assign o_pend_mask  = pend_mask_s;

    // Arbitration, starvation counting and next-state selection.
    always_comb begin
        grant_pipe_s = 1'b0;
        grant_fifo_s = 1'b0;
        state_nxt_s  = state_r;
        starve_nxt_s = starve_r;
        case (state_r)
            ST_NORMAL: begin
                if (pipe_req_s) begin
                    grant_pipe_s = 1'b1;
                end else begin
                    grant_fifo_s = ~fifo_empty_s;
                end
                if (fifo_empty_s || grant_fifo_s) begin
                    starve_nxt_s = 4'd0;
                end else if (starve_r == STARVE_LIMIT) begin
                    starve_nxt_s = 4'd0;
                    state_nxt_s  = ST_STALL;
                end else begin
                    starve_nxt_s = starve_r + 4'd1;
                end
            end
            ST_STALL: begin
                grant_fifo_s = ~fifo_empty_s;
                state_nxt_s  = ST_NORMAL;
                starve_nxt_s = 4'd0;
            end
            default: begin
                state_nxt_s  = ST_NORMAL;
                starve_nxt_s = 4'd0;
            end
        endcase
    end

    // Pending-register mask built from occupied FIFO slots.
    always_comb begin
        pend_mask_s = 32'd0;
        for (int i = 0; i < 2; i++) begin
            pend_mask_s = pend_mask_s | (fifo_vld_r[i] ? (32'd1 << fifo_addr_r[i]) : 32'd0);
        end
    end

    // State and starvation counter registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r  <= ST_NORMAL;
            starve_r <= 4'd0;
        end else begin
            state_r  <= state_nxt_s;
            starve_r <= starve_nxt_s;
        end
    end

    // FIFO storage; push and pop never touch the same slot.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fifo_vld_r <= 2'b00;
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_addr_r[i] <= 5'd0;
                fifo_data_r[i] <= 32'd0;
            end
        end else begin
            if (push_s) begin
                fifo_addr_r[wr_ptr_r] <= i_lu_addr;
                fifo_data_r[wr_ptr_r] <= i_lu_data;
                fifo_vld_r[wr_ptr_r]  <= 1'b1;
                wr_ptr_r              <= ~wr_ptr_r;
            end
            if (grant_fifo_s) begin
                fifo_vld_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r             <= ~rd_ptr_r;
            end
        end
    end

    // Register-file write port; address/data hold when nothing is granted.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            o_reg_RegWrite <= 1'b0;
            o_reg_RegAddrW <= 5'd0;
            o_reg_RegDataW <= 32'd0;
        end else if (grant_pipe_s) begin
            o_reg_RegWrite <= 1'b1;
            o_reg_RegAddrW <= i_pipe_RegAddrW;
            o_reg_RegDataW <= i_pipe_RegDataW;
        end else if (grant_fifo_s) begin
            o_reg_RegWrite <= 1'b1;
            o_reg_RegAddrW <= fifo_addr_r[rd_ptr_r];
            o_reg_RegDataW <= fifo_data_r[rd_ptr_r];
        end else begin
            o_reg_RegWrite <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regw_arbiter.sv
// Scoreboard bench for regw_arbiter: directed scenarios queue the expected
// register-file writes; a negedge monitor pops and compares each write.
module tb_regw_arbiter;

    logic        clk = 1'b0;
    logic        nrst;
    logic        i_pipe_RegWrite;
    logic [4:0]  i_pipe_RegAddrW;
    logic [31:0] i_pipe_RegDataW;
    logic        i_lu_valid;
    logic        o_lu_ready;
    logic [4:0]  i_lu_addr;
    logic [31:0] i_lu_data;
    logic        o_reg_RegWrite;
    logic [4:0]  o_reg_RegAddrW;
    logic [31:0] o_reg_RegDataW;
    logic        o_stall;
    logic [31:0] o_pend_mask;

    int total = 0;
    int bad   = 0;
    logic [36:0] exp_q [$];

    regw_arbiter #(.STARVE_MAX(4)) dut (
        .clk             (clk),
        .nrst            (nrst),
        .i_pipe_RegWrite (i_pipe_RegWrite),
        .i_pipe_RegAddrW (i_pipe_RegAddrW),
        .i_pipe_RegDataW (i_pipe_RegDataW),
        .i_lu_valid      (i_lu_valid),
        .o_lu_ready      (o_lu_ready),
        .i_lu_addr       (i_lu_addr),
        .i_lu_data       (i_lu_data),
        .o_reg_RegWrite  (o_reg_RegWrite),
        .o_reg_RegAddrW  (o_reg_RegAddrW),
        .o_reg_RegDataW  (o_reg_RegDataW),
        .o_stall         (o_stall),
        .o_pend_mask     (o_pend_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        i_pipe_RegWrite = pw;
        i_pipe_RegAddrW = pa;
        i_pipe_RegDataW = pd;
        i_lu_valid      = lv;
        i_lu_addr       = la;
        i_lu_data       = ld;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_stall"},   {31'd0, o_stall},        32'd0);
        chk({tag, "_wr_en"},   {31'd0, o_reg_RegWrite}, 32'd0);
        chk({tag, "_wr_addr"}, {27'd0, o_reg_RegAddrW}, 32'd0);
        chk({tag, "_wr_data"}, o_reg_RegDataW,          32'd0);
        chk({tag, "_pend"},    o_pend_mask,             32'd0);
        chk({tag, "_ready"},   {31'd0, o_lu_ready},     32'd1);
    endtask

    // Monitor: every presented write must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [36:0] e;
        if (nrst && o_reg_RegWrite) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected: got r%0d=0x%0h expected no write", o_reg_RegAddrW, o_reg_RegDataW);
            end else begin
                e = exp_q.pop_front();
                if ({o_reg_RegAddrW, o_reg_RegDataW} !== e) begin
                    bad++;
                    $display("FAIL wr_data: got r%0d=0x%0h expected r%0d=0x%0h",
                             o_reg_RegAddrW, o_reg_RegDataW, e[36:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        int k;
        nrst = 1'b0;
        idle();
        #3;
        chk_reset_values("rst");
        tick();
        nrst = 1'b1;

        // Pipe-only write of r5.
        expect_wr(5'd5, 32'h1234);
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        tick();
        idle();
        chk("pipe_stall", {31'd0, o_stall}, 32'd0);
        tick();
        tick();

        // Idle LU path: r9 pending for one cycle, written in cycle 2.
        expect_wr(5'd9, 32'hCAFE);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hCAFE);
        chk("lu_ready_c0", {31'd0, o_lu_ready}, 32'd1);
        tick();
        idle();
        chk("lu_pend_c1", o_pend_mask, 32'h0000_0200);
        tick();
        chk("lu_pend_c2", o_pend_mask, 32'd0);
        tick();
        tick();

        // Starvation: r3 waits while the pipe writes every cycle; stall in cycle 6.
        for (int i = 0; i < 6; i++) expect_wr(5'(10 + i), 32'hA000 + 32'(i));
        expect_wr(5'd3, 32'h33);
        expect_wr(5'd16, 32'hA006);
        k = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 5'(10 + k), 32'hA000 + 32'(k), (c == 0), 5'd3, 32'h33);
            tick();
            if (c != 6) k++;
            chk($sformatf("starve_stall_c%0d", c + 1), {31'd0, o_stall}, {31'd0, (c == 5)});
            if (c == 5) chk("starve_pend_c6", o_pend_mask, 32'h0000_0008);
        end
        idle();
        tick();
        chk("starve_pend_after", o_pend_mask, 32'd0);
        tick();
        tick();

        // Full FIFO and ordering: r1, r2 pushed while the pipe is busy.
        for (int i = 0; i < 4; i++) expect_wr(5'(16 + i), 32'hC000 + 32'(i));
        expect_wr(5'd1, 32'h111);
        expect_wr(5'd2, 32'h222);
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 5'(16 + c), 32'hC000 + 32'(c), (c < 2), (c == 0) ? 5'd1 : 5'd2,
                  (c == 0) ? 32'h111 : 32'h222);
            tick();
            chk($sformatf("full_ready_c%0d", c + 1), {31'd0, o_lu_ready}, {31'd0, (c == 0)});
            if (c == 1) chk("full_pend_c2", o_pend_mask, 32'h0000_0006);
        end
        idle();
        tick();
        chk("full_ready_c5", {31'd0, o_lu_ready}, 32'd1);
        tick();
        tick();
        tick();

        // Zero register from both sources: no writes, handshake still completes.
        drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        chk("zero_ready_c0", {31'd0, o_lu_ready}, 32'd1);
        tick();
        idle();
        chk("zero_pend_c1", o_pend_mask, 32'd0);
        chk("zero_ready_c1", {31'd0, o_lu_ready}, 32'd1);
        tick();
        tick();

        // Reset while full and stalled; the write granted in cycle 5 is discarded.
        for (int i = 0; i < 5; i++) expect_wr(5'(12 + i), 32'hB000 + 32'(i));
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 5'(12 + c), 32'hB000 + 32'(c), (c < 2), (c == 0) ? 5'd20 : 5'd21,
                  (c == 0) ? 32'h2020 : 32'h2121);
            tick();
        end
        drive(1'b1, 5'd18, 32'hB006, 1'b0, 5'd0, 32'd0);
        chk("mid_stall", {31'd0, o_stall}, 32'd1);
        chk("mid_ready", {31'd0, o_lu_ready}, 32'd0);
        #1;
        nrst = 1'b0;
        #1;
        chk_reset_values("mid_rst");
        idle();
        tick();
        tick();
        nrst = 1'b1;
        for (int c = 0; c < 4; c++) tick();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
